// File: rtl/counter_12_checker_if.sv
// Signal bundle between a monitored mod-N counter and its integrity checker.
// The master side drives the sampled counter/enable, the slave side is the checker.
interface counter_12_checker_if #(
  parameter int unsigned CW     = 4,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned WRAP_W = 8
);
  logic              valid_count;
  logic [CW-1:0]     cnt_in;
  logic              clr_err;
  logic              locked;
  logic              fault;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_count;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic [CW-1:0]     expected;

  modport master (
    output valid_count, cnt_in, clr_err,
    input  locked, fault, err_pulse, err_count, wrap_pulse, wrap_count, expected
  );

  modport slave (
    input  valid_count, cnt_in, clr_err,
    output locked, fault, err_pulse, err_count, wrap_pulse, wrap_count, expected
  );
endinterface

// File: rtl/counter_12_checker.sv
// Step-by-step legality checker for an enable-gated mod-MODULUS counter:
// predicts each sample from the previous one, tracks lock, counts faults and wraps.
module counter_12_checker #(
  parameter int unsigned MODULUS     = 12,
  parameter int unsigned CW          = 4,
  parameter int unsigned LOCK_THRESH = 4,
  parameter int unsigned ERR_W       = 8,
  parameter int unsigned WRAP_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  counter_12_checker_if.slave  mon_if
);

  localparam logic [0:0] ST_UNSYNC = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam int unsigned GW = $clog2(LOCK_THRESH + 1);
  localparam logic [GW-1:0] LockThr = GW'(LOCK_THRESH);
  localparam logic [CW-1:0] MaxVal  = CW'(MODULUS - 1);
  localparam logic [CW:0]   ModVal  = (CW + 1)'(MODULUS);

  logic [0:0]        r_state;
  logic [CW-1:0]     r_prev_cnt;
  logic              r_prev_en;
  logic              r_hist_vld;
  logic [GW-1:0]     r_good_run;
  logic              r_fault;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_count;
  logic              r_wrap_pulse;
  logic [WRAP_W-1:0] r_wrap_count;
  logic [CW-1:0]     r_expected;

  logic [CW-1:0]     w_exp;
  logic              w_match;
  logic              w_wrap_step;
  logic [0:0]        w_state_nxt;
  logic [GW-1:0]     w_good_run_nxt;
  logic              w_fault_nxt;
  logic              w_err_pulse_nxt;
  logic [ERR_W-1:0]  w_err_count_nxt;
  logic              w_wrap_pulse_nxt;
  logic [WRAP_W-1:0] w_wrap_count_nxt;

  assign w_exp       = r_prev_en ? ((r_prev_cnt == MaxVal) ? '0 : r_prev_cnt + 1'b1) : r_prev_cnt;
  // Range check keeps a corrupted prediction from ever matching an illegal value.
  assign w_match     = r_hist_vld && (mon_if.cnt_in == w_exp) && ({1'b0, mon_if.cnt_in} < ModVal);
  assign w_wrap_step = r_prev_en && (r_prev_cnt == MaxVal);

  always_comb begin
    w_state_nxt      = r_state;
    w_good_run_nxt   = r_good_run;
    w_fault_nxt      = r_fault;
    w_err_pulse_nxt  = 1'b0;
    w_err_count_nxt  = r_err_count;
    w_wrap_pulse_nxt = 1'b0;
    w_wrap_count_nxt = r_wrap_count;
    if (r_hist_vld) begin
      if (r_state == ST_UNSYNC) begin
        if (w_match) begin
          if (r_good_run < LockThr) w_good_run_nxt = r_good_run + 1'b1;
          if (w_good_run_nxt == LockThr) w_state_nxt = ST_LOCKED;
        end else begin
          w_good_run_nxt = '0;
        end
      end else if (w_match) begin
        if (w_wrap_step) begin
          w_wrap_pulse_nxt = 1'b1;
          if (r_wrap_count != '1) w_wrap_count_nxt = r_wrap_count + 1'b1;
        end
      end else begin
        w_err_pulse_nxt = 1'b1;
        if (r_err_count != '1) w_err_count_nxt = r_err_count + 1'b1;
        w_fault_nxt    = 1'b1;
        w_state_nxt    = ST_UNSYNC;
        w_good_run_nxt = '0;
      end
    end
    // Clear wins over a same-cycle error; the pulse and state drop still happen.
    if (mon_if.clr_err) begin
      w_fault_nxt     = 1'b0;
      w_err_count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNSYNC;
      r_prev_cnt   <= '0;
      r_prev_en    <= 1'b0;
      r_hist_vld   <= 1'b0;
      r_good_run   <= '0;
      r_fault      <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
      r_wrap_pulse <= 1'b0;
      r_wrap_count <= '0;
      r_expected   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev_cnt   <= mon_if.cnt_in;
      r_prev_en    <= mon_if.valid_count;
      r_hist_vld   <= 1'b1;
      r_good_run   <= w_good_run_nxt;
      r_fault      <= w_fault_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_err_count  <= w_err_count_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_expected   <= w_exp;
    end
  end

  assign mon_if.locked     = (r_state == ST_LOCKED);
  assign mon_if.fault      = r_fault;
  assign mon_if.err_pulse  = r_err_pulse;
  assign mon_if.err_count  = r_err_count;
  assign mon_if.wrap_pulse = r_wrap_pulse;
  assign mon_if.wrap_count = r_wrap_count;
  assign mon_if.expected   = r_expected;

endmodule

// File: tb/tb_counter_12_checker.sv
// Directed bench for counter_12_checker: lock/wrap, pause, skip, range, missed hold,
// error saturation with clear, and asynchronous reset mid-run.
module tb_counter_12_checker;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned WRAP_W = 8;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  int   c;

  counter_12_checker_if #(.CW(4), .ERR_W(ERR_W), .WRAP_W(WRAP_W)) mon_if ();

  counter_12_checker #(
    .MODULUS(12), .CW(4), .LOCK_THRESH(4), .ERR_W(ERR_W), .WRAP_W(WRAP_W)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mon_if (mon_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Drive one sample, let it be clocked in, then settle past the edge.
  task automatic step(input logic en, input int cnt, input logic clr);
    mon_if.valid_count = en;
    mon_if.cnt_in      = 4'(cnt);
    mon_if.clr_err     = clr;
    @(posedge clk);
    #1;
    mon_if.clr_err = 1'b0;
  endtask

  task automatic legal();
    c = (c + 1) % 12;
    step(1'b1, c, 1'b0);
  endtask

  task automatic skip(input logic clr);
    c = (c + 2) % 12;
    step(1'b1, c, clr);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".locked"}, int'(mon_if.locked), 0);
    chk({tag, ".fault"}, int'(mon_if.fault), 0);
    chk({tag, ".err_pulse"}, int'(mon_if.err_pulse), 0);
    chk({tag, ".err_count"}, int'(mon_if.err_count), 0);
    chk({tag, ".wrap_pulse"}, int'(mon_if.wrap_pulse), 0);
    chk({tag, ".wrap_count"}, int'(mon_if.wrap_count), 0);
    chk({tag, ".expected"}, int'(mon_if.expected), 0);
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    mon_if.valid_count = 1'b0;
    mon_if.cnt_in      = '0;
    mon_if.clr_err     = 1'b0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock and wrap: capture + 4 matches locks on the 5th edge.
    step(1'b1, 0, 1'b0);
    chk("lock.capture_expected", int'(mon_if.expected), 0);
    chk("lock.capture_locked", int'(mon_if.locked), 0);
    for (int k = 1; k <= 3; k++) step(1'b1, k, 1'b0);
    chk("lock.edge4_locked", int'(mon_if.locked), 0);
    chk("lock.edge4_expected", int'(mon_if.expected), 3);
    step(1'b1, 4, 1'b0);
    chk("lock.edge5_locked", int'(mon_if.locked), 1);
    for (int k = 5; k <= 11; k++) begin
      step(1'b1, k, 1'b0);
      chk("lock.no_early_wrap", int'(mon_if.wrap_pulse), 0);
    end
    step(1'b1, 0, 1'b0);
    chk("wrap.pulse", int'(mon_if.wrap_pulse), 1);
    chk("wrap.count", int'(mon_if.wrap_count), 1);
    step(1'b1, 1, 1'b0);
    chk("wrap.pulse_one_cycle", int'(mon_if.wrap_pulse), 0);
    chk("wrap.fault", int'(mon_if.fault), 0);
    chk("wrap.err_count", int'(mon_if.err_count), 0);

    // Pause at 5 for 20 cycles, then resume.
    for (int k = 2; k <= 4; k++) step(1'b1, k, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step(1'b0, 5, 1'b0);
      chk("pause.locked", int'(mon_if.locked), 1);
      chk("pause.err_pulse", int'(mon_if.err_pulse), 0);
      chk("pause.expected", int'(mon_if.expected), 5);
    end
    step(1'b1, 5, 1'b0);
    step(1'b1, 6, 1'b0);
    chk("resume.locked", int'(mon_if.locked), 1);
    chk("resume.expected", int'(mon_if.expected), 6);
    chk("resume.err_count", int'(mon_if.err_count), 0);

    // Go round once more (second wrap) to reach 5, then skip 5 -> 7.
    c = 6;
    for (int k = 0; k < 11; k++) legal();
    chk("skip.pre_c", c, 5);
    chk("skip.pre_wraps", int'(mon_if.wrap_count), 2);
    step(1'b1, 7, 1'b0);
    chk("skip.err_pulse", int'(mon_if.err_pulse), 1);
    chk("skip.fault", int'(mon_if.fault), 1);
    chk("skip.err_count", int'(mon_if.err_count), 1);
    chk("skip.locked", int'(mon_if.locked), 0);
    step(1'b1, 8, 1'b0);
    chk("skip.pulse_one_cycle", int'(mon_if.err_pulse), 0);
    step(1'b1, 9, 1'b0);
    step(1'b1, 10, 1'b0);
    chk("skip.relock_early", int'(mon_if.locked), 0);
    step(1'b1, 11, 1'b0);
    chk("skip.relock", int'(mon_if.locked), 1);
    chk("skip.fault_sticky", int'(mon_if.fault), 1);
    step(1'b1, 0, 1'b0);
    chk("skip.wrap_count", int'(mon_if.wrap_count), 3);

    // Case A: out-of-range value while locked.
    step(1'b1, 13, 1'b0);
    chk("range.err_pulse", int'(mon_if.err_pulse), 1);
    chk("range.err_count", int'(mon_if.err_count), 2);
    step(1'b1, 1, 1'b0);
    chk("range.unsync_no_err", int'(mon_if.err_count), 2);
    chk("range.unsync_no_pulse", int'(mon_if.err_pulse), 0);
    for (int k = 2; k <= 5; k++) step(1'b1, k, 1'b0);
    chk("range.relock", int'(mon_if.locked), 1);

    // Case B: counter advances while its enable was low.
    step(1'b0, 6, 1'b0);
    chk("hold.match_locked", int'(mon_if.locked), 1);
    step(1'b0, 7, 1'b0);
    chk("hold.err_pulse", int'(mon_if.err_pulse), 1);
    chk("hold.err_count", int'(mon_if.err_count), 3);
    chk("hold.locked", int'(mon_if.locked), 0);
    step(1'b1, 7, 1'b0);
    for (int k = 8; k <= 10; k++) step(1'b1, k, 1'b0);
    chk("hold.relock", int'(mon_if.locked), 1);

    // Asynchronous reset while locked with three wraps recorded.
    chk("rst.pre_wraps", int'(mon_if.wrap_count), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst.async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 3; k++) step(1'b1, k, 1'b0);
    chk("rst.relock_early", int'(mon_if.locked), 0);
    step(1'b1, 4, 1'b0);
    chk("rst.relock", int'(mon_if.locked), 1);

    // Error counter saturation at 2 bits, then clear against a same-cycle error.
    c = 4;
    for (int k = 0; k < 5; k++) begin
      skip(1'b0);
      chk("sat.err_count", int'(mon_if.err_count), sat_exp[k]);
      chk("sat.err_pulse", int'(mon_if.err_pulse), 1);
      chk("sat.fault", int'(mon_if.fault), 1);
      for (int j = 0; j < 4; j++) legal();
      chk("sat.relock", int'(mon_if.locked), 1);
    end
    skip(1'b1);
    chk("clr.err_count", int'(mon_if.err_count), 0);
    chk("clr.fault", int'(mon_if.fault), 0);
    chk("clr.err_pulse", int'(mon_if.err_pulse), 1);
    chk("clr.locked", int'(mon_if.locked), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/counter_12_checker.md
Name: counter_12_checker

Overview:
- Receive-side monitor for a mod-12 enable-gated counter. Samples the counter value together with the enable that drives it and checks that every step is legal: +1 with wrap 11→0 when enabled, hold when not.
- Reports lock status, counter faults and wrap events.
- Sits next to each counter instance as an integrity checker; fault flags feed the system status register.

Parameters:
- MODULUS, 12, counter modulus; legal values 0..MODULUS-1
- CW, 4, counter value width; must satisfy 2^CW >= MODULUS
- LOCK_THRESH, 4, consecutive matching samples needed to declare lock (1..15)
- ERR_W, 8, error counter width (saturating)
- WRAP_W, 8, wrap counter width (saturating)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- valid_count  in  1  enable driven into the monitored counter, sampled on the same edge as the counter
- cnt_in  in  CW  monitored counter output
- clr_err  in  1  synchronous clear of fault and err_count, single-cycle pulse
- locked  out  1  checker is in LOCKED state
- fault  out  1  sticky: a mismatch occurred while locked
- err_pulse  out  1  one-cycle pulse per counted error
- err_count  out  ERR_W  saturating count of errors
- wrap_pulse  out  1  one-cycle pulse per legal MODULUS-1→0 step while locked
- wrap_count  out  WRAP_W  saturating count of wraps
- expected  out  CW  registered prediction for the next sample (debug)

Behaviour:
- Reset, rst_n asynchronous, active-low, clock clk:
  - All outputs 0; state UNSYNC; hist_vld=0; good_run=0.
  - History registers prev_cnt=0, prev_en=0.
- History:
  - Every edge: prev_cnt<=cnt_in, prev_en<=valid_count, hist_vld<=1.
  - The first edge after reset release only captures history; no check is made on that edge.
- Prediction (combinational):
  - exp = prev_en ? (prev_cnt==MODULUS-1 ? 0 : prev_cnt+1) : prev_cnt.
  - The expected output is exp registered each edge.
- Match:
  - match = hist_vld && cnt_in==exp && cnt_in<MODULUS.
  - An out-of-range cnt_in (>=MODULUS) is always a mismatch, even if it equals a corrupted exp.
  - A non-match with hist_vld=1 is a mismatch.
- UNSYNC state:
  - On match, good_run increments (saturating at LOCK_THRESH). Reaching LOCK_THRESH moves the state to LOCKED.
  - On mismatch, good_run<=0 and no error is counted.
- LOCKED state:
  - On match: stay in LOCKED. If prev_en && prev_cnt==MODULUS-1, raise wrap_pulse and increment wrap_count (saturating).
  - On mismatch: raise err_pulse, increment err_count (saturating), set fault<=1, state<=UNSYNC, good_run<=0.
- Output timing:
  - locked = (state==LOCKED).
  - All outputs are registered. Pulses are high for exactly the cycle after the edge that sampled the triggering value.
- clr_err:
  - Clears fault and err_count on that edge.
  - Has priority over an increment in the same cycle: the result is err_count=0 and fault=0, but err_pulse still asserts and the state still drops to UNSYNC.
  - Does not affect state, good_run, wrap_count or history.
- Pause:
  - valid_count=0 with cnt_in holding is a match. Arbitrarily long pauses keep lock.
- Saturation:
  - err_count stops at 2^ERR_W-1 and wrap_count stops at 2^WRAP_W-1.
  - Pulses still assert when a counter is saturated.
- Reset mid-operation returns everything to its reset values immediately (asynchronously); checking restarts with a history capture.

Test Plan:
- Lock and wrap:
  - Stimulus: release reset, valid_count=1, cnt_in 0,1,2,…,11,0 one step per cycle.
  - Required: locked=1 after the 5th edge (capture + 4 matches); wrap_pulse exactly once at the 11→0 step; wrap_count=1; fault=0, err_count=0.
- Pause:
  - Stimulus: locked at cnt_in=5; valid_count=0 for 20 cycles with cnt_in=5; then resume at 6.
  - Required: locked stays 1; no err_pulse; expected=5 throughout the pause.
- Skip fault:
  - Stimulus: locked; cnt_in goes 5→7 with prev_en=1.
  - Required: err_pulse for 1 cycle; fault=1; err_count=1; locked=0. After 4 more legal steps, locked=1 and fault remains 1.
- Range and missed hold:
  - Stimulus, case A: locked, cnt_in=13 is injected → mismatch, err_count increments.
  - Stimulus, case B: locked, cnt_in advances with prev_en=0 → mismatch, err_count increments.
- Saturation and clear:
  - Stimulus: ERR_W=2; cause 5 locked-state mismatches, relocking between them; then pulse clr_err in the same cycle as a 6th mismatch.
  - Required: err_count sequence 1,2,3,3,3; err_pulse on all 5. On the 6th: err_count=0, fault=0, err_pulse=1.
- Reset mid-run:
  - Stimulus: assert rst_n=0 asynchronously while locked with wrap_count=3.
  - Required: all outputs 0 immediately. After release, locking again takes 5 edges.
